// File: rtl/tcm_sram.sv
// Tightly-coupled SRAM: read-only fetch port A, byte-lane read/write port B on one
// shared word array, configurable read latency and a clear FSM that zeroes the array.
module tcm_sram #(
  parameter int AW         = 14,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1,
  localparam int NB        = DW / 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          a_e,
  input  logic [AW-1:0] a_addr,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic [NB-1:0] b_we,
  input  logic [NB-1:0] b_re,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  input  logic          clr_req,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, CLEAR, READY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] mem [DEPTH];

  logic          ready;
  logic          a_acc;
  logic          b_rd;
  logic [NB-1:0] b_wr_lanes;
  logic          req_any;

  logic [RD_LAT-1:0] a_vld_p;
  logic [RD_LAT-1:0] b_vld_p;
  logic [DW-1:0]     a_dat_p [RD_LAT];
  logic [DW-1:0]     b_dat_p [RD_LAT];

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] en);
    logic [DW-1:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{en[i]}};
    return m;
  endfunction

  assign ready      = (state == READY);
  assign busy       = ~ready;
  assign a_acc      = ready & a_e;
  assign b_rd       = ready & (|b_re);
  assign b_wr_lanes = ready ? b_we : '0;
  assign req_any    = a_e | (|b_we) | (|b_re);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (CLR_ON_RST != 0) ? CLEAR : READY;
      CLEAR:   if (&clr_cnt) state_nxt = READY;
      READY:   if (clr_req) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter wraps to 0 on the last word, so a later clear starts from 0 again.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)                clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)                   drop_cnt <= '0;
    else if (busy && req_any)   drop_cnt <= sat_inc8(drop_cnt);
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        if (b_wr_lanes[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      a_vld_p <= '0;
      b_vld_p <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        a_dat_p[i] <= '0;
        b_dat_p[i] <= '0;
      end
    end else begin
      // Stage 0: array sampled at the request edge, before any same-edge write lands
      a_vld_p[0] <= a_acc;
      b_vld_p[0] <= b_rd;
      if (a_acc) a_dat_p[0] <= mem[a_addr];
      if (b_rd)  b_dat_p[0] <= mem[b_addr] & lane_mask(b_re);
      // Stages 1..RD_LAT-1: data advances only with its valid, so the output holds
      for (int i = 1; i < RD_LAT; i++) begin
        a_vld_p[i] <= a_vld_p[i-1];
        b_vld_p[i] <= b_vld_p[i-1];
        if (a_vld_p[i-1]) a_dat_p[i] <= a_dat_p[i-1];
        if (b_vld_p[i-1]) b_dat_p[i] <= b_dat_p[i-1];
      end
    end
  end

  assign a_rdata  = a_dat_p[RD_LAT-1];
  assign a_rvalid = a_vld_p[RD_LAT-1];
  assign b_rdata  = b_dat_p[RD_LAT-1];
  assign b_rvalid = b_vld_p[RD_LAT-1];

endmodule

// File: tb/tb_tcm_sram.sv
// Scoreboard bench for tcm_sram (AW=4, RD_LAT=2): expected {port, cycle, data} records
// are queued at request time and matched against captured rvalid beats.
module tb_tcm_sram;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        a_e;
  logic [3:0]  a_addr;
  logic [31:0] a_rdata;
  logic        a_rvalid;
  logic [3:0]  b_we;
  logic [3:0]  b_re;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata;
  logic [31:0] b_rdata;
  logic        b_rvalid;
  logic        clr_req;
  logic        busy;
  logic [7:0]  drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];

  tcm_sram #(.AW(4), .DW(32), .RD_LAT(LAT), .CLR_ON_RST(1)) dut (
    .clk(clk), .rstn(rstn),
    .a_e(a_e), .a_addr(a_addr), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_we(b_we), .b_re(b_re), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .clr_req(clr_req), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid beat, port A before port B within a cycle.
  always @(negedge clk) begin
    if (a_rvalid) obs_q.push_back({1'b0, 32'(cyc), a_rdata});
    if (b_rvalid) obs_q.push_back({1'b1, 32'(cyc), b_rdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic idle();
    a_e     = 1'b0;
    b_we    = '0;
    b_re    = '0;
    clr_req = 1'b0;
    a_addr  = 'x;
    b_addr  = 'x;
    b_wdata = 'x;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [3:0] we, input logic [31:0] d);
    b_we    = we;
    b_addr  = addr;
    b_wdata = d;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({a_rvalid, b_rvalid, a_rdata, b_rdata, drop_cnt, busy} !== {2'b00, 64'h0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got av=%b bv=%b ad=%h bd=%h drop=%0d busy=%b, required 0 0 0 0 0 1",
               a_rvalid, b_rvalid, a_rdata, b_rdata, drop_cnt, busy);
    end
    rstn = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    n_chk++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL reset_clear_len: got %0d busy cycles, required 16", n);
    end
  endtask

  task automatic test_clear_preload();
    logic [64:0] e, o;
    int n;
    for (int i = 0; i < 16; i++) write_word(4'(i), 4'hF, 32'hA5A5A5A5);
    a_e = 1'b1; a_addr = 4'd15;
    exp_q.push_back({1'b0, 32'(cyc + LAT), 32'hA5A5A5A5});
    @(negedge clk);
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    rstn = 1'b1;
    #1;
    n_chk++;
    if ({a_rvalid, a_rdata, busy} !== {1'b0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL preload_reset_async: got av=%b ad=%h busy=%b, required 0 0 1", a_rvalid, a_rdata, busy);
    end
    @(negedge clk);
    rstn = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    n_chk++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL preload_clear_len: got %0d busy cycles, required 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      a_e = 1'b1; a_addr = 4'(i);
      exp_q.push_back({1'b0, 32'(cyc + LAT), 32'h0});
      @(negedge clk);
    end
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL preload_rd: no read data, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL preload_rd: got %h, required %h", o, e);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL preload_extra: %0d unexpected rvalid, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_byte_write();
    logic [64:0] e, o;
    write_word(4'd3, 4'hF, 32'h12345678);
    write_word(4'd3, 4'b0100, 32'hFFAAFFFF);
    b_re = 4'hF; b_addr = 4'd3;
    exp_q.push_back({1'b1, 32'(cyc + LAT), 32'h12AA5678});
    @(negedge clk);
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL byte_write_rd: no read data, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL byte_write_rd: got %h, required %h", o, e);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL byte_write_extra: %0d unexpected rvalid, required 0", obs_q.size());
      obs_q.delete();
    end
    n_chk++;
    if ({b_rvalid, b_rdata} !== {1'b0, 32'h12AA5678}) begin
      n_fail++;
      $display("FAIL b_rdata_hold: got bv=%b bd=%h, required 0 12aa5678", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_collision();
    logic [64:0] e, o;
    write_word(4'd5, 4'hF, 32'h11111111);
    a_e = 1'b1; a_addr = 4'd5;
    b_we = 4'hF; b_re = 4'hF; b_addr = 4'd5; b_wdata = 32'h22222222;
    exp_q.push_back({1'b0, 32'(cyc + LAT), 32'h11111111});
    exp_q.push_back({1'b1, 32'(cyc + LAT), 32'h11111111});
    @(negedge clk);
    idle();
    a_e = 1'b1; a_addr = 4'd5;
    exp_q.push_back({1'b0, 32'(cyc + LAT), 32'h22222222});
    @(negedge clk);
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL collision_rd: no read data, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL collision_rd: got %h, required %h", o, e);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL collision_extra: %0d unexpected rvalid, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] e, o;
    logic [3:0]  re_tab [4];
    logic [31:0] bx_tab [4];
    write_word(4'd7, 4'hF, 32'hDEADBEEF);
    for (int i = 8; i < 12; i++) write_word(4'(i), 4'hF, 32'hC0DE0000 | 32'(i));
    re_tab = '{4'b0011, 4'b1000, 4'b0110, 4'b1111};
    bx_tab = '{32'h0000BEEF, 32'hDE000000, 32'h00ADBE00, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) begin
      a_e = 1'b1; a_addr = 4'(8 + i);
      b_re = re_tab[i]; b_addr = 4'd7;
      exp_q.push_back({1'b0, 32'(cyc + LAT), 32'hC0DE0008 + 32'(i)});
      exp_q.push_back({1'b1, 32'(cyc + LAT), bx_tab[i]});
      @(negedge clk);
    end
    idle();
    b_re = 4'b0110; b_addr = 4'd10;
    exp_q.push_back({1'b1, 32'(cyc + LAT), 32'h00DE0000});
    @(negedge clk);
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_rd: no read data, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL b2b_rd: got %h, required %h", o, e);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_extra: %0d unexpected rvalid, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_drop();
    logic [64:0] e, o;
    int n;
    a_e = 1'b1; a_addr = 4'd7; clr_req = 1'b1;
    exp_q.push_back({1'b0, 32'(cyc + LAT), 32'hDEADBEEF});
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      idle();
      if (busy) n++;
      if (i < 3) begin
        a_e = 1'b1; a_addr = 4'd0;
      end
      if (i == 5) clr_req = 1'b1;
    end
    n_chk++;
    if (drop_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL drop_count: got %0d, required 3", drop_cnt);
    end
    n_chk++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL clear_no_restart: got %0d busy cycles, required 16", n);
    end
    a_e = 1'b1; a_addr = 4'd7; b_re = 4'hF; b_addr = 4'd11;
    exp_q.push_back({1'b0, 32'(cyc + LAT), 32'h0});
    exp_q.push_back({1'b1, 32'(cyc + LAT), 32'h0});
    @(negedge clk);
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL drop_rd: no read data, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL drop_rd: got %h, required %h", o, e);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL drop_extra: %0d unexpected rvalid, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_drop_saturate();
    a_e = 1'b1; a_addr = 4'd0; clr_req = 1'b1;
    repeat (400) @(negedge clk);
    idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    repeat (LAT + 2) @(negedge clk);
    n_chk++;
    if (drop_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL drop_saturate: got %0d, required 255", drop_cnt);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_clear();
    logic [64:0] e, o;
    int n;
    for (int i = 0; i < 16; i++) write_word(4'(i), 4'hF, 32'h5A5A5A5A);
    a_e = 1'b1; a_addr = 4'd2;
    @(negedge clk);
    idle();
    repeat (LAT + 2) @(negedge clk);
    obs_q.delete();
    clr_req = 1'b1;
    @(negedge clk);
    idle();
    repeat (7) @(negedge clk);
    rstn = 1'b1;
    #1;
    n_chk++;
    if ({a_rvalid, b_rvalid, a_rdata, b_rdata, drop_cnt, busy} !== {2'b00, 64'h0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL midclear_reset: got av=%b bv=%b ad=%h bd=%h drop=%0d busy=%b, required 0 0 0 0 0 1",
               a_rvalid, b_rvalid, a_rdata, b_rdata, drop_cnt, busy);
    end
    @(negedge clk);
    rstn = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    n_chk++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL midclear_len: got %0d busy cycles, required 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      a_e = 1'b1; a_addr = 4'(i);
      exp_q.push_back({1'b0, 32'(cyc + LAT), 32'h0});
      @(negedge clk);
    end
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL midclear_rd: no read data, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL midclear_rd: got %h, required %h", o, e);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL midclear_extra: %0d unexpected rvalid, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clear_preload();
    test_byte_write();
    test_collision();
    test_back_to_back();
    test_drop();
    test_drop_saturate();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
